// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit holding the HI/LO pair: shift-add multiply, restoring divide.
// Optional zero-operand early completion is enabled by defining MULDIV_EARLY_OUT_EN.
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src0_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic [WIDTH-1:0]   abs0, abs1;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_rsh, div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               early;

  assign is_signed = (op_i == 3'd0) || (op_i == 3'd2);
  assign abs0 = (is_signed && src0_i[WIDTH-1]) ? (WIDTH'(0) - src0_i) : src0_i;
  assign abs1 = (is_signed && src1_i[WIDTH-1]) ? (WIDTH'(0) - src1_i) : src1_i;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient}.
  assign div_rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_rsh - {1'b0, opb_q};
  assign div_step = div_diff[WIDTH] ? {div_rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q_q ? ((2*WIDTH)'(0) - mul_step) : mul_step;
  assign quo_fix  = div0_q ? '1 : (neg_q_q ? (WIDTH'(0) - div_step[WIDTH-1:0]) : div_step[WIDTH-1:0]);
  assign rem_fix  = neg_r_q ? (WIDTH'(0) - div_step[2*WIDTH-1:WIDTH]) : div_step[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
  assign early = (op_i[1] == 1'b0) ? ((src0_i == '0) || (src1_i == '0))
                                   : ((src0_i == '0) && (src1_i != '0));
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    div0_d  = div0_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          case (op_i)
            3'd4: hi_d = src0_i;
            3'd5: lo_d = src0_i;
            3'd0, 3'd1, 3'd2, 3'd3: begin
              cnt_d   = '0;
              neg_q_d = is_signed && (src0_i[WIDTH-1] ^ src1_i[WIDTH-1]);
              neg_r_d = is_signed && src0_i[WIDTH-1];
              div0_d  = op_i[1] && (src1_i == '0);
              if (op_i[1]) begin
                acc_d   = {{WIDTH{1'b0}}, abs0};
                opb_d   = abs1;
                state_d = DIV;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, abs1};
                opb_d   = abs0;
                state_d = MUL;
              end
              if (early) begin
                hi_d    = '0;
                lo_d    = '0;
                done_d  = 1'b1;
                state_d = FIX;
              end
            end
            default: ;
          endcase
        end
      end
      MUL, DIV: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = (state_q == MUL) ? mul_step : div_step;
          cnt_d = cnt_q + 1'b1;
          // Sign correction is folded into the final step so HI/LO land with done_o.
          if (cnt_q == CW'(ITER - 1)) begin
            if (state_q == MUL) begin
              hi_d = prod_fix[2*WIDTH-1:WIDTH];
              lo_d = prod_fix[WIDTH-1:0];
            end else begin
              hi_d = rem_fix;
              lo_d = quo_fix;
            end
            done_d  = 1'b1;
            state_d = FIX;
          end
        end
      end
      FIX: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      div0_q  <= div0_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Sequential multiply/divide unit with the architectural HI/LO register pair.
- Sits beside the EX stage. The pipeline issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here and reads results back via hi_o/lo_o (for MFHI/MFLO).
- Replaces the single-cycle combinational 64-bit {hi,lo} result path with an iterative engine.
- Uses a start/busy/done handshake so the hazard unit can stall.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- ITER, 32, iterations per mul/div operation; must equal WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start_i  input  1  issue request; sampled only in IDLE
- op_i  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, others=no-op
- src0_i  input  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO data)
- src1_i  input  WIDTH  rt value (divisor / multiplier)
- flush_i  input  1  abort the in-flight operation (exception/interrupt)
- busy_o  output  1  high while state != IDLE
- done_o  output  1  one-cycle pulse when HI/LO are updated by mul/div
- hi_o  output  WIDTH  current HI register
- lo_o  output  WIDTH  current LO register

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE
  - hi_o=0, lo_o=0, busy_o=0, done_o=0
  - internal accumulators cleared
  - Overrides start_i and flush_i.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start_i=1:
  - op 4: HI<=src0_i next edge; stay IDLE, no done_o.
  - op 5: LO<=src0_i next edge; stay IDLE, no done_o.
  - op 0-3:
    - Latch operand magnitudes. Signed ops take two's-complement absolute value; unsigned ops take raw values.
    - Latch sign flags: neg_q = s0^s1 (signed only); neg_r = s0 (signed only).
    - Clear the iteration counter.
    - Go to MUL (op 0-1) or DIV (op 2-3).
  - op 6-7: ignored.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product accumulator; after ITER cycles go to FIX.
- DIV: restoring division, one quotient bit per cycle (2*WIDTH remainder, compare/subtract/shift); after ITER cycles go to FIX.
- FIX:
  - Apply sign correction:
    - MULT: negate 64-bit product if neg_q.
    - DIV: negate quotient if neg_q; negate remainder if neg_r.
  - Write HI = upper product / remainder; LO = lower product / quotient.
  - Pulse done_o; go to IDLE.
- Latency: start edge in cycle 0; done_o and the new HI/LO visible in cycle ITER+1. busy_o high cycles 1..ITER+1.
- Back-to-back issue: a new start_i is accepted in the cycle after done_o (state=IDLE).
- start_i while busy: ignored; the pipeline must stall on busy_o.
- Divide by zero:
  - LO=all ones, HI=src0_i (raw value, signed or unsigned).
  - No trap; completes with normal latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no ov flag).
- flush_i=1:
  - Any non-IDLE state: go to IDLE next edge; HI/LO unchanged; no done_o.
  - In IDLE: suppresses a concurrent start_i, including MTHI/MTLO.
- HI/LO change only on MTHI/MTLO, FIX, or rst.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- When defined, in IDLE for op 0-3:
  - If src0_i==0 or src1_i==0 for MULT/MULTU: go directly to FIX with a zero product; done_o in cycle 1.
  - For DIV/DIVU with src0_i==0 and src1_i!=0: HI=LO=0, same early done.
  - Divide-by-zero still takes full latency.
- When undefined: every mul/div takes ITER+1 cycles.

Test Plan:
- rst held 2 cycles, then released -> hi_o=0, lo_o=0, busy_o=0, done_o=0.
- MULT src0=0xFFFFFFFE (-2), src1=0x00000003 -> done_o at cycle 33; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU src0=0xFFFFFFFF, src1=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV src0=0xFFFFFFF9 (-7), src1=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- Start DIVU 100/7, assert flush_i at cycle 10, then MTLO 0x1234 -> no done_o; busy_o low at cycle 11; HI unchanged; LO=0x1234.
- Start MULTU, assert start_i again at cycles 5 and 20 -> extra starts ignored; single done_o at cycle 33. With MULDIV_EARLY_OUT_EN, MULT 0 x 5 -> done_o at cycle 1, HI=LO=0.
